// File: rtl/fht_pkg.sv
// Shared types, constants and elaboration helpers for the FHT twiddle generator.
package fht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Quadrant codes taken from the top two bits of the full-circle index.
  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  // Quarter-wave table holds N/4+1 words (both endpoints included).
  function automatic int qtab_depth(int n_log2);
    return (1 << (n_log2 - 2)) + 1;
  endfunction

  function automatic int qtab_aw(int n_log2);
    return $clog2(qtab_depth(n_log2));
  endfunction

  function automatic int clamp_stage(int s, int n_log2);
    return (s >= n_log2) ? (n_log2 - 1) : s;
  endfunction

  // Entry m = round(full_scale * sin(pi*m/(N/2))). Evaluated at elaboration only;
  // a Taylor series keeps it free of math-library calls.
  function automatic int qsin_entry(int m, int n_log2, int w_bit);
    real x, term, acc, amp;
    x    = 3.14159265358979323846 * real'(m) / real'(1 << (n_log2 - 1));
    term = x;
    acc  = x;
    for (int i = 1; i < 12; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      acc  = acc + term;
    end
    amp = real'((1 << (w_bit - 1)) - 1);
    return $rtoi(amp * acc + 0.5);
  endfunction

endpackage

// File: rtl/fht_twiddle_gen_if.sv
// Control/stream bundle between a twiddle consumer (master) and the generator (slave).
interface fht_twiddle_gen_if #(
  parameter int W_BIT  = 12,
  parameter int N_LOG2 = 8
);
  localparam int SW = $clog2(N_LOG2);

  logic                    iSTART;
  logic [SW-1:0]           iSTAGE;
  logic                    iREADY;
  logic                    oVALID;
  logic signed [W_BIT-1:0] oSIN;
  logic signed [W_BIT-1:0] oCOS;
  logic [N_LOG2-2:0]       oK;
  logic                    oLAST;
  logic                    oBUSY;

  modport master (output iSTART, iSTAGE, iREADY,
                  input  oVALID, oSIN, oCOS, oK, oLAST, oBUSY);
  modport slave  (input  iSTART, iSTAGE, iREADY,
                  output oVALID, oSIN, oCOS, oK, oLAST, oBUSY);
endinterface

// File: rtl/fht_rom.sv
// Quarter-wave sine ROM with registered address; contents are generated from
// W_BIT/N_LOG2 at elaboration using the same rounding as the qsin table.
module fht_rom
  import fht_pkg::*;
#(
  parameter int DW     = 12,
  parameter int N_LOG2 = 8,
  parameter int DEPTH  = 65,
  parameter int AW     = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] q
);

  logic [DEPTH-1:0][DW-1:0] tbl;
  logic [AW-1:0]            addr_q, addr_d;

  for (genvar m = 0; m < DEPTH; m++) begin : g_tbl
    localparam int VAL = qsin_entry(m, N_LOG2, DW);
    assign tbl[m] = DW'(VAL);
  end

  // Only load the address when a read is issued to avoid idle toggling.
  always_comb addr_d = en ? addr : addr_q;

  // Address register; data appears one clock after issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_q <= '0;
    else        addr_q <= addr_d;
  end

  assign q = tbl[addr_q];

endmodule

// File: rtl/fht_twiddle_gen.sv
// Streaming (sin, cos) twiddle generator: walks k = 0..2^s-1 for a stage,
// rebuilds each pair from a quarter-wave table via quadrant symmetry, and
// feeds a 2-entry output FIFO under ready/valid flow control.
module fht_twiddle_gen
  import fht_pkg::*;
#(
  parameter int W_BIT  = 12,
  parameter int N_LOG2 = 8
) (
  input  logic               iCLK,
  input  logic               iRESET,
  fht_twiddle_gen_if.slave   tw
);

  localparam int SW    = $clog2(N_LOG2);
  localparam int KW    = N_LOG2 - 1;
  localparam int RW    = N_LOG2 - 2;
  localparam int DEPTH = qtab_depth(N_LOG2);
  localparam int AW    = qtab_aw(N_LOG2);
  localparam logic [AW-1:0] QUARTER = AW'(DEPTH - 1);

  typedef struct packed {
    logic [1:0]    quad;
    logic [KW-1:0] k;
    logic          last;
  } meta_t;

  typedef struct packed {
    logic [W_BIT-1:0] sin;
    logic [W_BIT-1:0] cos;
    logic [KW-1:0]    k;
    logic             last;
  } beat_t;

  state_e         state_q, state_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [KW-1:0]  k_q, k_d, k_max;
  logic [N_LOG2-1:0] idx;
  logic [1:0]     quad;
  logic [RW-1:0]  rem;
  logic [AW-1:0]  addr_dir, addr_mir;
  logic           issue, credit_ok, push, pop, valid;
  logic           rd_vld_q, rd_vld_d;
  meta_t          meta_q, meta_d;
  logic [W_BIT-1:0] t_dir, t_mir;
  beat_t          wr_beat, head;
  beat_t [1:0]    mem_q, mem_d;
  logic           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]     cnt_q, cnt_d;

  // Index -> quadrant/remainder -> direct and mirrored table addresses.
  always_comb begin
    k_max    = KW'((32'd1 << stage_q) - 32'd1);
    idx      = {1'b0, k_q} << (KW - int'(stage_q));
    quad     = idx[N_LOG2-1 -: 2];
    rem      = idx[RW-1:0];
    addr_dir = AW'(rem);
    addr_mir = QUARTER - AW'(rem);
  end

  assign valid = (cnt_q != 2'd0);
  assign pop   = valid && tw.iREADY;
  assign push  = rd_vld_q;
  assign head  = mem_q[rd_ptr_q];
  // A read issued now lands one cycle after the in-flight one, so the slots
  // left after this cycle's pop must cover both.
  assign credit_ok = (int'(cnt_q) - int'(pop) + int'(rd_vld_q)) < 2;

  // Sequencer: capture stage, issue one address per credit, wait for last beat.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    k_d      = k_q;
    issue    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (tw.iSTART) begin
          stage_d = SW'(clamp_stage(int'(tw.iSTAGE), N_LOG2));
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        issue = credit_ok;
        if (issue) begin
          if (k_q == k_max) state_d = ST_DRAIN;
          else              k_d     = k_q + KW'(1);
        end
      end
      ST_DRAIN: begin
        if (pop && head.last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rd_vld_d = issue;
    meta_d   = '{quad: quad, k: k_q, last: (k_q == k_max)};
  end

  // Sequencer and read-tracking registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q  <= ST_IDLE;
      stage_q  <= '0;
      k_q      <= '0;
      rd_vld_q <= 1'b0;
      meta_q   <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      k_q      <= k_d;
      rd_vld_q <= rd_vld_d;
      meta_q   <= meta_d;
    end
  end

  fht_rom #(.DW(W_BIT), .N_LOG2(N_LOG2), .DEPTH(DEPTH), .AW(AW)) u_rom_dir (
    .clk(iCLK), .rst_n(iRESET), .en(issue), .addr(addr_dir), .q(t_dir)
  );

  fht_rom #(.DW(W_BIT), .N_LOG2(N_LOG2), .DEPTH(DEPTH), .AW(AW)) u_rom_mir (
    .clk(iCLK), .rst_n(iRESET), .en(issue), .addr(addr_mir), .q(t_mir)
  );

  // Quadrant symmetry: swap and negate the two table reads.
  always_comb begin
    wr_beat      = '0;
    wr_beat.k    = meta_q.k;
    wr_beat.last = meta_q.last;
    case (meta_q.quad)
      QUAD_0:  begin wr_beat.sin = t_dir;  wr_beat.cos = t_mir;  end
      QUAD_1:  begin wr_beat.sin = t_mir;  wr_beat.cos = -t_dir; end
      QUAD_2:  begin wr_beat.sin = -t_dir; wr_beat.cos = -t_mir; end
      default: begin wr_beat.sin = -t_mir; wr_beat.cos = t_dir;  end
    endcase
  end

  // Output FIFO next-state; the credit check guarantees push never overflows.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_beat;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
  end

  // Output FIFO storage and pointers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload is zeroed when no beat is presented.
  assign tw.oVALID = valid;
  assign tw.oSIN   = valid ? head.sin  : '0;
  assign tw.oCOS   = valid ? head.cos  : '0;
  assign tw.oK     = valid ? head.k    : '0;
  assign tw.oLAST  = valid ? head.last : 1'b0;
  assign tw.oBUSY  = (state_q != ST_IDLE);

endmodule
